// File: rtl/cart_freeze_ctrl_if.sv
`timescale 1ns/1ps
// CPU-side bus seen by the cartridge freeze controller: address/strobe/qualifiers in,
// cartridge select and autovector override data out.
interface cart_freeze_ctrl_if;
    logic [23:1] cpu_address_in;
    logic        _cpu_as;
    logic        cpu_rd;
    logic        dbr;
    logic        ovl;
    logic [31:0] cpu_vbr;
    logic        sel_cart;
    logic        ovr;
    logic [15:0] vec_data_out;

    // Bus protocol: no valid/ready pairing here; the CPU qualifies every access with
    // _cpu_as (low = address valid) and cpu_rd, and the controller answers combinationally.
    modport master (
        output cpu_address_in, _cpu_as, cpu_rd, dbr, ovl, cpu_vbr,
        input  sel_cart, ovr, vec_data_out
    );

    modport slave (
        input  cpu_address_in, _cpu_as, cpu_rd, dbr, ovl, cpu_vbr,
        output sel_cart, ovr, vec_data_out
    );
endinterface

// File: rtl/cart_freeze_ctrl.sv
`timescale 1ns/1ps
// Cartridge freeze controller: debounced freeze buttons raise a level-7 interrupt, and the
// following autovector fetch is overridden so the CPU jumps into the cartridge ROM handler.
module cart_freeze_ctrl #(
    parameter int          NCH     = 4,
    parameter int          DB_LEN  = 16,
    parameter logic [31:0] VEC_OFS = 32'h0000_007C,
    localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             cpu_rst,
    input  logic             clk7_en,
    input  logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   chan_mask,
    cart_freeze_ctrl_if.slave bus,
    output logic             int7,
    output logic             active,
    output logic [CW-1:0]    active_ch,
    output logic [NCH-1:0]   pend,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        VECT = 2'd2
    } state_t;

    localparam logic [7:0] DB_TOP = 8'(DB_LEN - 1);

    state_t         state_q, state_d;
    logic           int7_q, int7_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [CW-1:0]  low_ch;

    logic [NCH-1:0] flt_q, flt_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] pend_clr;
    logic [7:0]     cnt_q [NCH];
    logic [7:0]     cnt_d [NCH];

    logic [31:0]    nmi_vec_adr;
    logic           int7_ack;
    logic [15:0]    vec_data;
    logic           unused_bits;

    // Only bits [23:2] of the vector address take part in the address compare.
    assign unused_bits = ^{nmi_vec_adr[31:24], nmi_vec_adr[1:0]};

    assign int7_ack     = (&bus.cpu_address_in) & ~bus._cpu_as;
    assign bus.sel_cart = ~bus.dbr & (bus.cpu_address_in[23:19] == 5'b10100);
    assign bus.ovr      = (state_q == VECT) & ~bus.dbr & ~bus.ovl & bus.cpu_rd &
                          (bus.cpu_address_in[23:2] == nmi_vec_adr[23:2]);

    // High word of the vector points into the cartridge ROM, low word selects the
    // per-channel handler entry 16 bytes apart.
    always_comb begin
        vec_data = 16'h0000;
        if (bus.ovr) begin
            if (bus.cpu_address_in[1])
                vec_data = 16'h000C + (16'(ch_q) << 4);
            else
                vec_data = 16'h00A1;
        end
    end
    assign bus.vec_data_out = vec_data;

    always_comb begin
        flt_d = flt_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = 8'd0;
            if (trig[i] != flt_q[i]) begin
                if (cnt_q[i] == DB_TOP)
                    flt_d[i] = ~flt_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
        rise = flt_d & ~flt_q & chan_mask;
    end

    // A fresh edge on the channel being acknowledged keeps its pend bit set.
    always_comb begin
        pend_clr = '0;
        if ((state_q == REQ) && int7_ack) begin
            for (int i = 0; i < NCH; i++)
                if (ch_q == CW'(i))
                    pend_clr[i] = 1'b1;
        end
        pend_d = (pend_q & ~pend_clr) | rise;
    end

    always_comb begin
        low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (pend_q[i])
                low_ch = CW'(i);
    end

    always_comb begin
        state_d = state_q;
        int7_d  = int7_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = REQ;
                    int7_d  = 1'b1;
                    ch_d    = low_ch;
                end
            end
            REQ: begin
                if (int7_ack) begin
                    state_d = VECT;
                    int7_d  = 1'b0;
                end
            end
            VECT: begin
                if (bus.cpu_rd && bus.sel_cart)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                int7_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            int7_q      <= 1'b0;
            ch_q        <= '0;
            pend_q      <= '0;
            flt_q       <= '0;
            nmi_vec_adr <= VEC_OFS;
            for (int i = 0; i < NCH; i++)
                cnt_q[i] <= 8'd0;
        end else if (clk7_en) begin
            state_q     <= state_d;
            int7_q      <= int7_d;
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            flt_q       <= flt_d;
            nmi_vec_adr <= bus.cpu_vbr + VEC_OFS;
            for (int i = 0; i < NCH; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign int7      = int7_q;
    assign active    = (state_q == VECT);
    assign active_ch = ch_q;
    assign pend      = pend_q;
    assign state_dbg = state_q;

endmodule
